// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which core port owns the transaction in flight
//   to_width()  : counter width for a given timeout (at least 1 bit)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  function automatic int to_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Wait-state watchdog for the memory arbiter.
//   clk        : clock
//   i_rst_n    : asynchronous active-low reset
//   i_clear    : restart the count from zero (held while not waiting)
//   i_enable   : count one cycle spent waiting
//   o_expired  : high in the last allowed waiting cycle
module arb_timeout_counter #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 4
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Count starts at 0 in the first waiting cycle, so this fires in the
  // TIMEOUT-th consecutive waiting cycle.
  assign o_expired = i_enable && (r_count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported memory between the core's fetch port
// and data port. One transaction at a time, data has fixed priority over
// fetch because it belongs to the older instruction.
//   clk, rst                       : clock, asynchronous active-low reset
//   if_req/if_addr                 : fetch request, held until if_valid
//   if_rdata/if_valid              : registered instruction, 1-cycle pulse
//   d_rd/d_wr/d_addr/d_wdata       : data request, held until d_valid
//   d_rdata/d_valid                : registered load data, 1-cycle pulse
//   core_stall                     : a port is waiting for its response
//   mem_req/mem_we/mem_addr/wdata  : request to memory
//   mem_ready                      : memory accepts the request this cycle
//   mem_rdata/mem_rvalid           : read response, in order
//   bus_err                        : sticky read-timeout flag
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  d_rd,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_valid,
  output logic                  core_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  bus_err
);

  localparam int TO_W = to_width(TIMEOUT);

  arb_state_t            r_state;
  arb_owner_t            r_owner;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic                  r_bus_err;

  logic                  w_d_sel;
  logic                  w_any_req;
  logic                  w_accept;
  logic                  w_in_wait;
  logic                  w_expired;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_rdata_cap;

  assign w_d_sel   = d_rd | d_wr;
  assign w_any_req = w_d_sel | if_req;
  assign w_in_wait = (r_state == WAIT_IF) || (r_state == WAIT_D);

  // Arbitration is purely combinational in IDLE, so a data request that
  // shows up while a fetch is being back-pressured takes the port over.
  // rst gates mem_req so memory sees no request while reset is held.
  assign mem_req   = rst && (r_state == IDLE) && w_any_req;
  assign mem_we    = mem_req && d_wr;
  assign mem_addr  = w_d_sel ? d_addr : if_addr;
  assign mem_wdata = d_wdata;
  assign w_accept  = mem_req && mem_ready;

  // A timed-out read returns zero to its owner.
  assign w_done      = w_in_wait && (mem_rvalid || w_expired);
  assign w_rdata_cap = mem_rvalid ? mem_rdata : '0;

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk       (clk),
    .i_rst_n   (rst),
    .i_clear   (!w_in_wait),
    .i_enable  (w_in_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_owner    <= OWN_IF;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_d_sel) begin
              r_owner <= OWN_D;
              // Writes need no response from memory; rd&wr counts as a write.
              r_state <= d_wr ? RESP : WAIT_D;
            end else begin
              r_owner <= OWN_IF;
              r_state <= WAIT_IF;
            end
          end
        end
        WAIT_IF, WAIT_D: begin
          if (w_done) begin
            r_state <= RESP;
            if (!mem_rvalid) r_bus_err <= 1'b1;
            if (r_state == WAIT_D) r_d_rdata  <= w_rdata_cap;
            else                   r_if_rdata <= w_rdata_cap;
          end
        end
        // One dead cycle so the requester can drop its held request
        // before IDLE would grant it a second time.
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_valid   = (r_state == RESP) && (r_owner == OWN_IF);
  assign d_valid    = (r_state == RESP) && (r_owner == OWN_D);
  assign if_rdata   = r_if_rdata;
  assign d_rdata    = r_d_rdata;
  assign bus_err    = r_bus_err;
  assign core_stall = (if_req & ~if_valid) | (w_d_sel & ~d_valid);

endmodule
